// File: rtl/ins_fetch_mem_if.sv
// Fetch request/response handshake bundle between the PC stage and decode.
// The master drives requests and response-ready; the slave is the fetch engine.
interface ins_fetch_mem_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned ADDR_W  = 16
);
   logic               req_valid;
   logic               req_ready;
   logic [ADDR_W-1:0]  req_pc;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [INSTR_W-1:0] rsp_ins;
   logic [ADDR_W-1:0]  rsp_pc;
   logic               rsp_fault;

   modport master (
      output req_valid, req_pc, rsp_ready,
      input  req_ready, rsp_valid, rsp_ins, rsp_pc, rsp_fault
   );

   modport slave (
      input  req_valid, req_pc, rsp_ready,
      output req_ready, rsp_valid, rsp_ins, rsp_pc, rsp_fault
   );
endinterface

// File: rtl/ins_fetch_mem.sv
// Byte-organised instruction memory with a multi-beat big-endian fetch engine.
// Optional feature macro: IMEM_FAULT_EN (PC alignment / overflow checking).
module ins_fetch_mem #(
   parameter int unsigned        INSTR_W  = 16,
   parameter int unsigned        DEPTH    = 256,
   parameter int unsigned        ADDR_W   = 16,
   parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              reset,
   ins_fetch_mem_if.slave    bus,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data
);

   localparam int unsigned BEATS  = INSTR_W / 8;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BEAT_W = $clog2(BEATS + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FAULT = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t             state;
   logic [BEAT_W-1:0]  beat;
   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] shreg;
   logic               alive_q;
   logic               rsp_valid_q;
   logic [INSTR_W-1:0] rsp_ins_q;
   logic [ADDR_W-1:0]  rsp_pc_q;
   logic               rsp_fault_q;

   logic [7:0]         mem [DEPTH];

   logic               ready_c;
   logic               accept_c;
   logic               last_beat_c;
   logic               req_fault_c;
   logic [ADDR_W-1:0]  rd_addr_c;
   logic [IDX_W-1:0]   rd_idx_c;
   logic [IDX_W-1:0]   ld_idx_c;
   logic [7:0]         rd_byte_c;
   logic [INSTR_W-1:0] shift_c;

   // Ready is held low while reset is asserted; in HOLD it follows the consumer.
   assign ready_c     = ((state == S_IDLE) && alive_q) ||
                        ((state == S_HOLD) && bus.rsp_ready);
   assign accept_c    = bus.req_valid && ready_c && !flush;
   assign last_beat_c = (beat == BEAT_W'(BEATS - 1));

   assign rd_addr_c   = pc_q + ADDR_W'(beat);
   assign rd_idx_c    = IDX_W'(rd_addr_c);
   assign ld_idx_c    = IDX_W'(ld_addr);
   assign rd_byte_c   = mem[rd_idx_c];
   assign shift_c     = {shreg[INSTR_W-9:0], rd_byte_c};

`ifdef IMEM_FAULT_EN
   logic [ADDR_W:0]    end_addr_c;
   logic               misalign_c;
   logic               overflow_c;

   // Last byte of the instruction must lie inside the array; PC must be word aligned.
   assign end_addr_c  = {1'b0, bus.req_pc} + (ADDR_W+1)'(BEATS - 1);
   assign misalign_c  = (bus.req_pc % ADDR_W'(BEATS)) != '0;
   assign overflow_c  = end_addr_c >= (ADDR_W+1)'(DEPTH);
   assign req_fault_c = misalign_c || overflow_c;
`else
   assign req_fault_c = 1'b0;
`endif

   assign bus.req_ready = ready_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_ins   = rsp_ins_q;
   assign bus.rsp_pc    = rsp_pc_q;
   assign bus.rsp_fault = rsp_fault_q;

   // Program load port; the read above sees the pre-write byte in the same cycle.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_idx_c] <= ld_data;
      end
   end

   // Fetch engine: state, beat counter, shift register and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         beat        <= '0;
         pc_q        <= '0;
         shreg       <= '0;
         alive_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ins_q   <= NOP_WORD;
         rsp_pc_q    <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (flush) begin
            state       <= S_IDLE;
            beat        <= '0;
            rsp_valid_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept_c) begin
                     pc_q  <= bus.req_pc;
                     shreg <= '0;
                     beat  <= '0;
                     state <= req_fault_c ? S_FAULT : S_FETCH;
                  end
               end

               S_FETCH: begin
                  shreg <= shift_c;
                  if (last_beat_c) begin
                     beat        <= '0;
                     state       <= S_HOLD;
                     rsp_valid_q <= 1'b1;
                     rsp_ins_q   <= shift_c;
                     rsp_pc_q    <= pc_q;
                     rsp_fault_q <= 1'b0;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end

               S_FAULT: begin
                  state       <= S_HOLD;
                  rsp_valid_q <= 1'b1;
                  rsp_ins_q   <= NOP_WORD;
                  rsp_pc_q    <= pc_q;
                  rsp_fault_q <= 1'b1;
               end

               S_HOLD: begin
                  if (accept_c) begin
                     // Back-to-back: hand off the response and start the next fetch.
                     pc_q        <= bus.req_pc;
                     shreg       <= '0;
                     beat        <= '0;
                     rsp_valid_q <= 1'b0;
                     state       <= req_fault_c ? S_FAULT : S_FETCH;
                  end else if (bus.rsp_ready) begin
                     rsp_valid_q <= 1'b0;
                     state       <= S_IDLE;
                  end
               end

               default: begin
                  state       <= S_IDLE;
                  beat        <= '0;
                  rsp_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
